// File: rtl/ftoi_pipe.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter with round-to-nearest.
// Optional overflow flag output enabled by defining FTOI_OVF_EN.
module ftoi_pipe #(
    parameter int unsigned TIE_AWAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FTOI_OVF_EN
    ,
    output logic        ovf
`endif
);

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic        v1;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_man;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_man  <= '0;
        end else if (advance) begin
            v1      <= in_valid;
            s1_sign <= x[31];
            s1_exp  <= x[30:23];
            s1_man  <= {|x[30:23], x[22:0]};
        end
    end

    logic [7:0]  sh_r;
    logic [2:0]  sh_l;
    logic [48:0] wide;
    logic [31:0] a_mag;
    logic        a_guard;
    logic        a_sticky;
    logic        a_zero;
    logic        a_big;
    logic        a_nan;
    logic        a_min;

    // Below exp 150 the mantissa shifts right, leaving guard and sticky in the low
    // 25 bits; from 150 up it shifts left with no fraction left over.
    always_comb begin
        sh_r     = 8'd150 - s1_exp;
        sh_l     = s1_exp[2:0] - 3'd6;
        wide     = {s1_man, 25'b0} >> sh_r;
        a_zero   = s1_exp < 8'd126;
        a_big    = s1_exp >= 8'd158;
        a_nan    = (s1_exp == 8'hFF) && (s1_man[22:0] != '0);
        a_min    = (s1_exp == 8'd158) && s1_sign && (s1_man[22:0] == '0);
        a_mag    = {8'b0, wide[48:25]};
        a_guard  = wide[24];
        a_sticky = |wide[23:0];
        if (s1_exp >= 8'd150) begin
            a_mag    = {8'b0, s1_man} << sh_l;
            a_guard  = 1'b0;
            a_sticky = 1'b0;
        end
    end

    logic        v2;
    logic        s2_sign;
    logic [31:0] s2_mag;
    logic        s2_guard;
    logic        s2_sticky;
    logic        s2_zero;
    logic        s2_big;
    logic        s2_nan;
    logic        s2_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_zero   <= 1'b0;
            s2_big    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_min    <= 1'b0;
        end else if (advance) begin
            v2        <= v1;
            s2_sign   <= s1_sign;
            s2_mag    <= a_mag;
            s2_guard  <= a_guard;
            s2_sticky <= a_sticky;
            s2_zero   <= a_zero;
            s2_big    <= a_big;
            s2_nan    <= a_nan;
            s2_min    <= a_min;
        end
    end

    logic        round_up;
    logic [31:0] rounded;
    logic [31:0] result;

    // Rounding works on the magnitude; the sign is applied afterwards.
    always_comb begin
        round_up = s2_guard & (s2_sticky | (TIE_AWAY != 0) | s2_mag[0]);
        rounded  = s2_mag + {31'b0, round_up};
        if (s2_nan) begin
            result = 32'h7FFF_FFFF;
        end else if (s2_min) begin
            result = 32'h8000_0000;
        end else if (s2_big) begin
            result = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (s2_zero) begin
            result = '0;
        end else begin
            result = s2_sign ? ('0 - rounded) : rounded;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (advance) begin
            out_valid <= v2;
            y         <= result;
        end
    end

`ifdef FTOI_OVF_EN
    logic ovf_next;

    always_comb begin
        ovf_next = s2_nan | (s2_big & ~s2_min);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: vector table through both rounding modes,
// plus stall and mid-flight reset sequences.
module tb_ftoi_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready0;
    logic [31:0] y;
    logic [31:0] y0;
    logic        out_valid;
    logic        out_valid0;
    logic        out_ready;
    logic        ovf;
    logic        ovf0;

    int passed = 0;
    int total  = 0;

    ftoi_pipe #(.TIE_AWAY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FTOI_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    ftoi_pipe #(.TIE_AWAY(0)) dut_even (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .y         (y0),
        .out_valid (out_valid0),
        .out_ready (out_ready)
`ifdef FTOI_OVF_EN
        ,
        .ovf       (ovf0)
`endif
    );

`ifndef FTOI_OVF_EN
    assign ovf  = 1'b0;
    assign ovf0 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] xv;
        logic [31:0] y_away;
        logic [31:0] y_even;
        logic        ovf_exp;
        string       name;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    task automatic send(input logic [31:0] xv, output logic [31:0] ya, output logic [31:0] yb,
                        output logic oa, output int lat);
        lat = -1;
        ya  = 'x;
        yb  = 'x;
        oa  = 1'bx;
        @(negedge clk);
        x         = xv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid) begin
                lat = k;
                ya  = y;
                yb  = y0;
                oa  = ovf;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] ya;
        logic [31:0] yb;
        logic        oa;
        int          lat;
        logic [31:0] sx[4];
        int          sent;
        int          recv;
        int          extra;
        logic        hold_v;
        logic [31:0] hold_y;
        logic        seen;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, "zero"};
        vecs[1]  = '{32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, "neg_denorm"};
        vecs[2]  = '{32'h3FC0_0000, 32'h0000_0002, 32'h0000_0002, 1'b0, "p1_5"};
        vecs[3]  = '{32'h4020_0000, 32'h0000_0003, 32'h0000_0002, 1'b0, "p2_5"};
        vecs[4]  = '{32'hBF00_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "m0_5"};
        vecs[5]  = '{32'h3EFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, "below_half"};
        vecs[6]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "p2e31"};
        vecs[7]  = '{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, "m2e31"};
        vecs[8]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "qnan"};
        vecs[9]  = '{32'hFFC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "neg_nan"};
        vecs[10] = '{32'hFF80_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, "neg_inf"};
        vecs[11] = '{32'h7F80_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "pos_inf"};
        vecs[12] = '{32'h3F40_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, "p0_75"};
        vecs[13] = '{32'hC060_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, "m3_5"};
        vecs[14] = '{32'h4B00_0001, 32'h0080_0001, 32'h0080_0001, 1'b0, "exp150"};
        vecs[15] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80, 1'b0, "exp157"};
        vecs[16] = '{32'hCF00_0001, 32'h8000_0000, 32'h8000_0000, 1'b1, "m_ovf"};
        vecs[17] = '{32'h3F8C_CCCD, 32'h0000_0001, 32'h0000_0001, 1'b0, "p1_1"};
        vecs[18] = '{32'hBFC0_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, "m1_5"};
        vecs[19] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF, 1'b0, "exp150_max"};
        vecs[20] = '{32'h4AFF_FFFD, 32'h007F_FFFF, 32'h007F_FFFE, 1'b0, "tie_big"};

        rst       = 1'b1;
        x         = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_y",         y,                  32'd0);
        chk("rst_y_even",    y0,                 32'd0);
`ifdef FTOI_OVF_EN
        chk("rst_ovf",       {31'b0, ovf},       32'd0);
`endif

        for (int i = 0; i < 21; i++) begin
            send(vecs[i].xv, ya, yb, oa, lat);
            chk({vecs[i].name, "_lat"},  lat, 32'd3);
            chk({vecs[i].name, "_away"}, ya,  vecs[i].y_away);
            chk({vecs[i].name, "_even"}, yb,  vecs[i].y_even);
`ifdef FTOI_OVF_EN
            chk({vecs[i].name, "_ovf"}, {31'b0, oa}, {31'b0, vecs[i].ovf_exp});
`endif
        end

        // Back-to-back 1.0..4.0 with out_ready low in cycles 3..7
        @(negedge clk);
        sx[0]  = 32'h3F80_0000;
        sx[1]  = 32'h4000_0000;
        sx[2]  = 32'h4040_0000;
        sx[3]  = 32'h4080_0000;
        sent   = 0;
        recv   = 0;
        extra  = 0;
        hold_v = 1'b0;
        hold_y = '0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            if (sent < 4) begin
                in_valid = 1'b1;
                x        = sx[sent];
            end else begin
                in_valid = 1'b0;
                x        = '0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                if (hold_v) chk("stall_hold_y", y, hold_y);
                hold_v = 1'b1;
                hold_y = y;
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (recv < 4) chk("stall_order", y, 32'(recv + 1));
                else extra++;
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_sent",  sent,  32'd4);
        chk("stall_recv",  recv,  32'd4);
        chk("stall_extra", extra, 32'd0);

        // Reset two cycles after accepting 3.0, with a stray operand during reset
        @(negedge clk);
        x        = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = 32'h4200_0000;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mid_rst_y",         y,                  32'd0);
`ifdef FTOI_OVF_EN
        chk("mid_rst_ovf",       {31'b0, ovf},       32'd0);
`endif
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_flushed", {31'b0, seen}, 32'd0);

        send(32'h4120_0000, ya, yb, oa, lat);
        chk("post_rst_lat", lat, 32'd3);
        chk("post_rst_y",   ya,  32'd10);
        chk("post_rst_y_even", yb, 32'd10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ftoi_pipe.md
FTOI_PIPE -- requirements
Module: ftoi_pipe

Interface
REQ-001 SHALL have parameter: TIE_AWAY, 1, rounding of exact .5 fractions (1 = away from zero, 0 = to even).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: x  input  32  IEEE-754 single operand.
REQ-005 SHALL have port: in_valid  input  1  x valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block accepts x this cycle.
REQ-007 SHALL have port: y  output  32  two's-complement signed integer result.
REQ-008 SHALL have port: out_valid  output  1  y valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes y this cycle.
REQ-010 SHALL have port (only with FTOI_OVF_EN): ovf  output  1  result saturated or operand NaN/Inf.

Function
REQ-011 SHALL be a 3-stage pipeline: S1 register operand (sign, exp, {1,frac}); S2 align mantissa by (exp-127) with guard/sticky bits; S3 round, negate, saturate, drive y/out_valid.
REQ-012 SHALL have latency exactly 3 cycles from accept (in_valid & in_ready) to out_valid with out_ready held high; throughput 1/cycle.
REQ-013 SHALL use a global stall: advance = ~out_valid | out_ready; in_ready = advance; all stages hold when advance=0.
REQ-014 SHALL keep y and out_valid stable while out_valid=1 and out_ready=0.
REQ-015 SHALL carry a valid bit per stage; bubbles propagate and are not compressed.
REQ-016 SHALL output 0 for exp < 126 (|x| < 0.5) and for denormals/zero, sign ignored.
REQ-017 SHALL, for exp = 126, output 0 or ±1 per rounding mode (0.5 is a tie).
REQ-018 SHALL round on guard bit; tie when guard=1 and sticky=0; non-tie rounds to nearest.
REQ-019 SHALL output exact value for 150 <= exp <= 157 (no fractional bits).
REQ-020 SHALL saturate for exp >= 158: positive -> 0x7FFFFFFF, negative -> 0x80000000.
REQ-021 SHALL treat -2^31 exactly (x = 0xCF000000) as representable: y = 0x80000000, not overflow.
REQ-022 SHALL map NaN (exp=255, frac!=0) to 0x7FFFFFFF regardless of sign; ±Inf saturates per REQ-020.
REQ-023 SHALL apply negation after rounding (rounding symmetric in magnitude).
REQ-024 SHALL hold y = 0 when out_valid = 0 only after reset; otherwise y is don't-care when out_valid = 0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear all stage valid bits, y, and ovf to 0 on that edge.
REQ-026 SHALL drive out_valid=0 and in_ready=1 in the cycle after reset; in_valid during rst is ignored.
REQ-027 SHALL discard in-flight operands on reset mid-operation; none emerge afterward.

Configuration
REQ-028 SHALL, with macro FTOI_OVF_EN defined, provide ovf: 1 with y for REQ-020 saturation (except REQ-021), NaN, Inf; else 0; held with y under stall.
REQ-029 SHALL, without FTOI_OVF_EN, omit the ovf port and its logic; y behaviour is identical.

Verification
REQ-030 SHALL cover: x=0x3FC00000 (1.5) -> y=2; x=0x40200000 (2.5) -> y=3 (TIE_AWAY=1), y=2 (TIE_AWAY=0).
REQ-031 SHALL cover: x=0xBF000000 (-0.5) -> y=0xFFFFFFFF (TIE_AWAY=1), y=0 (TIE_AWAY=0); x=0x3EFFFFFF -> y=0.
REQ-032 SHALL cover: x=0x4F000000 -> y=0x7FFFFFFF, ovf=1; x=0xCF000000 -> y=0x80000000, ovf=0; x=0x7FC00000 -> y=0x7FFFFFFF, ovf=1.
REQ-033 SHALL cover: inputs 1,2,3,4 (as floats) back-to-back, out_ready=0 for cycles 3-7 -> in_ready low while stalled, outputs 1,2,3,4 in order, none lost/duplicated.
REQ-034 SHALL cover: rst asserted 2 cycles after accepting 0x40400000 -> no out_valid for that operand; next operand 0x41200000 -> y=10 after 3 cycles.
